// File: rtl/card_pkg.sv
// Shared constants, state encoding and perm_flat slicing for the card shuffler.
// Card k's slot lives at perm_flat[slot_lsb(k) +: IDX_W]; the position-finding stage uses the same slicing.
package card_pkg;

    localparam int NUM_CARDS = 16;
    localparam int IDX_W     = 4;

    localparam int                LFSR_W       = 16;
    localparam logic [LFSR_W-1:0] LFSR_MASK    = 16'hB400;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_DRAW,
        ST_SWAP,
        ST_DONE
    } shuf_state_e;

    function automatic int slot_lsb(input int card);
        return card * IDX_W;
    endfunction

endpackage

// File: rtl/card_shuffler_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), free-running, with a synchronous load.
// An all-zero state is stuck, so it is replaced by SEED on the following cycle.
module lfsr16
    import card_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (load) begin
            q <= load_val;
        end else if (q == '0) begin
            q <= SEED;
        end else begin
            q <= (q >> 1) ^ (q[0] ? LFSR_MASK : '0);
        end
    end

endmodule

// File: rtl/card_shuffler.sv
// LFSR-driven Fisher-Yates shuffle of NUM_CARDS grid slots; entry k is the slot of card k.
// Build option CARD_SHUFFLER_FIXED_SEED_EN reloads the LFSR with SEED on every accepted start.
//
// state | meaning
// IDLE  | waiting for start; last published permutation held
// INIT  | working array reset to identity, i = NUM_CARDS-1
// DRAW  | j = (lfsr[7:0] * (i+1)) >> 8 registered
// SWAP  | arr[i] <-> arr[j], i decrements; leaves after i == 1
// DONE  | done pulse; permutation already visible on perm_flat
module card_shuffler
    import card_pkg::*;
#(
    parameter int                NUM_CARDS = card_pkg::NUM_CARDS,
    parameter int                IDX_W     = card_pkg::IDX_W,
    parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED
) (
    input  logic                       FPGA_Clk,
    input  logic                       FPGA_Rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       valid,
    output logic [NUM_CARDS*IDX_W-1:0] perm_flat
);

    localparam int PROD_W = 8 + IDX_W + 1;
    localparam logic [IDX_W:0] ONE = 1;

    shuf_state_e state_q, state_d;

    logic [IDX_W-1:0]           i_q, j_q;
    logic [IDX_W-1:0]           arr_q   [NUM_CARDS];
    logic [IDX_W-1:0]           arr_swp [NUM_CARDS];
    logic [NUM_CARDS*IDX_W-1:0] perm_q;
    logic                       valid_q;
    logic [LFSR_W-1:0]          lfsr_q;
    logic                       lfsr_load;
    logic [PROD_W-1:0]          prod;
    logic                       accept;
    logic                       last_swap;
    logic                       unused_lfsr_hi;

    assign accept    = (state_q == ST_IDLE) && start;
    assign last_swap = (state_q == ST_SWAP) && (i_q == IDX_W'(1));

`ifdef CARD_SHUFFLER_FIXED_SEED_EN
    assign lfsr_load = accept;
`else
    assign lfsr_load = 1'b0;
`endif

    lfsr16 #(
        .SEED(SEED)
    ) u_lfsr (
        .clk     (FPGA_Clk),
        .rst_n   (FPGA_Rst_n),
        .load    (lfsr_load),
        .load_val(SEED),
        .q       (lfsr_q)
    );

    // Scaling the byte by (i+1) keeps j in 0..i without a modulo.
    assign prod           = PROD_W'(lfsr_q[7:0]) * PROD_W'({1'b0, i_q} + ONE);
    assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:8];

    always_ff @(posedge FPGA_Clk or negedge FPGA_Rst_n) begin
        if (!FPGA_Rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_INIT;
            ST_INIT: state_d = ST_DRAW;
            ST_DRAW: state_d = ST_SWAP;
            ST_SWAP: state_d = (i_q == IDX_W'(1)) ? ST_DONE : ST_DRAW;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < NUM_CARDS; k++) begin
            arr_swp[k] = arr_q[k];
        end
        arr_swp[i_q] = arr_q[j_q];
        arr_swp[j_q] = arr_q[i_q];
    end

    // The final swap is published on the same edge that enters DONE, so the
    // new permutation is already on perm_flat while done is high.
    always_ff @(posedge FPGA_Clk or negedge FPGA_Rst_n) begin
        if (!FPGA_Rst_n) begin
            i_q     <= '0;
            j_q     <= '0;
            valid_q <= 1'b0;
            for (int k = 0; k < NUM_CARDS; k++) begin
                arr_q[k]                         <= IDX_W'(k);
                perm_q[slot_lsb(k) +: IDX_W]     <= IDX_W'(k);
            end
        end else begin
            case (state_q)
                ST_INIT: begin
                    i_q <= IDX_W'(NUM_CARDS - 1);
                    for (int k = 0; k < NUM_CARDS; k++) begin
                        arr_q[k] <= IDX_W'(k);
                    end
                end
                ST_DRAW: j_q <= prod[8 +: IDX_W];
                ST_SWAP: begin
                    i_q <= i_q - IDX_W'(1);
                    for (int k = 0; k < NUM_CARDS; k++) begin
                        arr_q[k] <= arr_swp[k];
                    end
                end
                default: ;
            endcase
            if (last_swap) begin
                valid_q <= 1'b1;
                for (int k = 0; k < NUM_CARDS; k++) begin
                    perm_q[slot_lsb(k) +: IDX_W] <= arr_swp[k];
                end
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign valid     = valid_q;
    assign perm_flat = perm_q;

endmodule

// File: tb/tb_card_shuffler.sv
// Bench for card_shuffler: random-timed deals checked every cycle against a behavioural shuffle model.
module tb_card_shuffler;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [63:0] IDENT = 64'hFEDCBA9876543210;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, valid;
    logic [63:0] perm_flat;

    int vectors = 0;
    int errors  = 0;

    card_shuffler dut (
        .FPGA_Clk  (clk),
        .FPGA_Rst_n(rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .valid     (valid),
        .perm_flat (perm_flat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        if (v == 16'h0) return SEED;
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // v0 is the LFSR value in the INIT cycle; draws use every other value after it.
    function automatic logic [63:0] shuffle_from(input logic [15:0] v0);
        int          a [16];
        int          j, t;
        logic [15:0] v;
        logic [63:0] p;
        for (int k = 0; k < 16; k++) a[k] = k;
        v = v0;
        for (int i = 15; i >= 1; i--) begin
            v = lfsr_step(v);
            j = (int'(v[7:0]) * (i + 1)) >> 8;
            t = a[i]; a[i] = a[j]; a[j] = t;
            v = lfsr_step(v);
        end
        for (int k = 0; k < 16; k++) p[k*4 +: 4] = 4'(a[k]);
        return p;
    endfunction

    function automatic bit is_perm(input logic [63:0] p);
        logic [15:0] seen;
        seen = '0;
        for (int k = 0; k < 16; k++) seen[p[k*4 +: 4]] = 1'b1;
        return seen == 16'hFFFF;
    endfunction

    // Model: m_cnt counts remaining busy cycles (32 in INIT, 1 on the done cycle).
    logic [15:0] m_lfsr;
    logic [63:0] m_perm, m_pend;
    logic        m_valid;
    int          m_cnt;

    always @(posedge clk or negedge rst_n) begin
        logic        acc;
        logic [15:0] nxt;
        if (!rst_n) begin
            m_lfsr  = SEED;
            m_perm  = IDENT;
            m_pend  = IDENT;
            m_valid = 1'b0;
            m_cnt   = 0;
        end else begin
            acc = (m_cnt == 0) && start;
            nxt = lfsr_step(m_lfsr);
`ifdef CARD_SHUFFLER_FIXED_SEED_EN
            if (acc) nxt = SEED;
`endif
            if (acc) begin
                m_cnt  = 32;
                m_pend = shuffle_from(nxt);
            end else if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
            end
            if (m_cnt == 1) begin
                m_perm  = m_pend;
                m_valid = 1'b1;
            end
            m_lfsr = nxt;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 64'(busy), 64'(m_cnt != 0));
            chk("done", 64'(done), 64'(m_cnt == 1));
            chk("valid", 64'(valid), 64'(m_valid));
            chk("perm_flat", perm_flat, m_perm);
            if (done) chk("perm_is_permutation", 64'(is_perm(perm_flat)), 64'd1);
        end
    end

    task automatic deal_once(output int busy_cnt, output int done_at, output int done_cnt);
        busy_cnt = 0; done_at = -1; done_cnt = 0;
        start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = n;
            end
        end
    endtask

    int bc, da, dc;
    int hist [16];
    bit got;

    initial begin
        for (int s = 0; s < 16; s++) hist[s] = 0;

        chk("model_step_ace1", 64'(lfsr_step(16'hACE1)), 64'h E270);
        chk("model_step_zero", 64'(lfsr_step(16'h0000)), 64'h ACE1);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        repeat (7) @(negedge clk);
        chk("reset_perm", perm_flat, IDENT);
        chk("reset_valid", 64'(valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);

        deal_once(bc, da, dc);
        chk("single_busy_cycles", 64'(bc), 64'd32);
        chk("single_done_offset", 64'(da), 64'd32);
        chk("single_done_count", 64'(dc), 64'd1);

        // start held through whole deals: back-to-back deals, one idle cycle apart
        dc = 0;
        start = 1'b1;
        for (int n = 1; n <= 99; n++) begin
            @(negedge clk);
            if (done) dc++;
            if (n == 99) start = 1'b0;
        end
        chk("held_start_done_count", 64'(dc), 64'd3);
        repeat (40) @(negedge clk);

        // reset in the middle of a deal
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        chk("midreset_valid", 64'(valid), 64'd0);
        chk("midreset_perm", perm_flat, IDENT);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        deal_once(bc, da, dc);
        chk("after_reset_busy_cycles", 64'(bc), 64'd32);
        chk("after_reset_done_offset", 64'(da), 64'd32);
        chk("after_reset_done_count", 64'(dc), 64'd1);

        // random-timed deals with start noise while busy
        for (int d = 0; d < 1000; d++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            start = 1'b1;
            got = 1'b0;
            for (int n = 1; n <= 40; n++) begin
                @(negedge clk);
                if (done) begin
                    got = 1'b1;
                    start = 1'b0;
                    break;
                end
                start = 1'($urandom % 2);
            end
            start = 1'b0;
            if (!got) chk("deal_timeout", 64'd0, 64'd1);
            else for (int k = 0; k < 8; k++) hist[perm_flat[k*4 +: 4]]++;
            @(negedge clk);
        end

`ifndef CARD_SHUFFLER_FIXED_SEED_EN
        for (int s = 0; s < 16; s++)
            chk($sformatf("hist_slot%0d_in_400_600(count=%0d)", s, hist[s]),
                64'(hist[s] >= 400 && hist[s] <= 600), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
